// File: rtl/map_pkg.sv
// Shared constants for the map scan generator and the map/digit renderer.
// Timing, window geometry and colours live here so both sides agree.
package map_pkg;

  localparam int CLK_DIV   = 4;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam int MAP_X0    = 85;
  localparam int MAP_Y0    = 10;
  localparam int MAP_W     = 470;
  localparam int MAP_H     = 460;
  localparam int PHY_WIDTH = 14;

  localparam logic [11:0] MAP_COLOR   = 12'h0A4;
  localparam logic [11:0] DIGIT_COLOR = 12'hFF0;

  localparam int DIGIT_WIDTH = 16;
  localparam int DIGIT_X0    = 20;
  localparam int DIGIT_Y0    = 20;

  // Half-open interval test: lo <= x < hi.
  function automatic logic in_span(input logic [10:0] x,
                                   input logic [10:0] lo,
                                   input logic [10:0] hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Pixel-rate divider plus horizontal/vertical raster counters.
// tick is high for the clk in which the divider is at its last count.
module vga_sync_counter #(
  parameter int CLK_DIV = 4,
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525
) (
  input  logic       clk,
  input  logic       rst,
  output logic       tick,
  output logic [9:0] h,
  output logic [9:0] v
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div;

  assign tick = (div == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
      h   <= '0;
      v   <= '0;
    end else begin
      if (tick) begin
        div <= '0;
      end else begin
        div <= div + 1'b1;
      end
      if (tick) begin
        if (h == 10'(H_TOTAL - 1)) begin
          h <= '0;
          if (v == 10'(V_TOTAL - 1)) begin
            v <= '0;
          end else begin
            v <= v + 1'b1;
          end
        end else begin
          h <= h + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/map_scan_gen.sv
// VGA timing and map-window coordinate generator; every output is registered
// on the pixel tick from the pre-increment raster position.
module map_scan_gen #(
  parameter int CLK_DIV   = map_pkg::CLK_DIV,
  parameter int H_DISPLAY = map_pkg::H_DISPLAY,
  parameter int H_FRONT   = map_pkg::H_FRONT,
  parameter int H_SYNC    = map_pkg::H_SYNC,
  parameter int H_BACK    = map_pkg::H_BACK,
  parameter int V_DISPLAY = map_pkg::V_DISPLAY,
  parameter int V_FRONT   = map_pkg::V_FRONT,
  parameter int V_SYNC    = map_pkg::V_SYNC,
  parameter int V_BACK    = map_pkg::V_BACK,
  parameter int MAP_X0    = map_pkg::MAP_X0,
  parameter int MAP_Y0    = map_pkg::MAP_Y0,
  parameter int MAP_W     = map_pkg::MAP_W,
  parameter int MAP_H     = map_pkg::MAP_H,
  parameter int PHY_WIDTH = map_pkg::PHY_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           camera_y_in,
  output logic                 pixel_tick,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 video_on,
  output logic [9:0]           pixel_x,
  output logic [9:0]           pixel_y,
  output logic                 map_on,
  output logic [PHY_WIDTH-1:0] map_x,
  output logic [PHY_WIDTH-1:0] map_y,
  output logic [4:0]           camera_y,
  output logic                 frame_start
);

  import map_pkg::*;

  localparam int H_TOT    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT    = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int VS_START = V_DISPLAY + V_FRONT;

  logic        tick;
  logic [9:0]  h;
  logic [9:0]  v;

  logic [10:0] hx;
  logic [10:0] vx;
  logic        hs_n;
  logic        vs_n;
  logic        vid;
  logic        mon;
  logic [10:0] dx;
  logic [10:0] dy;
  logic        first;
  logic        cam_sample;

  vga_sync_counter #(
    .CLK_DIV(CLK_DIV),
    .H_TOTAL(H_TOT),
    .V_TOTAL(V_TOT)
  ) u_counter (
    .clk (clk),
    .rst (rst),
    .tick(tick),
    .h   (h),
    .v   (v)
  );

  always_comb begin
    hx         = {1'b0, h};
    vx         = {1'b0, v};
    hs_n       = !in_span(hx, 11'(HS_START), 11'(HS_START + H_SYNC));
    vs_n       = !in_span(vx, 11'(VS_START), 11'(VS_START + V_SYNC));
    vid        = (hx < 11'(H_DISPLAY)) && (vx < 11'(V_DISPLAY));
    mon        = in_span(hx, 11'(MAP_X0), 11'(MAP_X0 + MAP_W)) &&
                 in_span(vx, 11'(MAP_Y0), 11'(MAP_Y0 + MAP_H));
    dx         = hx - 11'(MAP_X0);
    dy         = vx - 11'(MAP_Y0);
    first      = (h == '0) && (v == '0);
    // Level index is latched at the first pixel of vertical blanking.
    cam_sample = (h == '0) && (vx == 11'(V_DISPLAY));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_tick  <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      map_on      <= 1'b0;
      map_x       <= '0;
      map_y       <= '0;
      camera_y    <= '0;
      frame_start <= 1'b0;
    end else begin
      pixel_tick  <= tick;
      frame_start <= 1'b0;
      if (tick) begin
        hsync       <= hs_n;
        vsync       <= vs_n;
        video_on    <= vid;
        pixel_x     <= vid ? h : '0;
        pixel_y     <= vid ? v : '0;
        map_on      <= mon;
        map_x       <= mon ? PHY_WIDTH'(dx) : '0;
        map_y       <= mon ? PHY_WIDTH'(dy) : '0;
        frame_start <= first;
        if (cam_sample) begin
          camera_y <= camera_y_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_map_scan_gen.sv
// Bench for map_scan_gen on a shrunken raster (80x55 total, 4 clks/pixel).
// A pixel-level model feeds a scoreboard; probes and multi-cycle checks run in the main flow.
module tb_map_scan_gen;

  localparam int CD  = 4;
  localparam int HD  = 64, HF = 4, HS = 8, HB = 4;
  localparam int VD  = 48, VF = 2, VS = 2, VB = 3;
  localparam int HT  = HD + HF + HS + HB;
  localparam int VT  = VD + VF + VS + VB;
  localparam int MX0 = 8, MY0 = 3, MW = 47, MH = 40;

  logic        clk;
  logic        rst;
  logic [4:0]  camera_y_in;
  logic        pixel_tick;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        map_on;
  logic [13:0] map_x;
  logic [13:0] map_y;
  logic [4:0]  camera_y;
  logic        frame_start;

  map_scan_gen #(
    .CLK_DIV(CD), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .MAP_X0(MX0), .MAP_Y0(MY0), .MAP_W(MW), .MAP_H(MH), .PHY_WIDTH(14)
  ) dut (
    .clk(clk), .rst(rst), .camera_y_in(camera_y_in), .pixel_tick(pixel_tick),
    .hsync(hsync), .vsync(vsync), .video_on(video_on), .pixel_x(pixel_x),
    .pixel_y(pixel_y), .map_on(map_on), .map_x(map_x), .map_y(map_y),
    .camera_y(camera_y), .frame_start(frame_start)
  );

  typedef struct {
    int          h;
    int          v;
    logic [9:0]  px;
    logic [9:0]  py;
    logic        hs;
    logic        vs;
    logic        vid;
    logic        mon;
    logic [13:0] mx;
    logic [13:0] my;
    logic [4:0]  cam;
    logic        fs;
  } exp_t;

  typedef struct {
    int          h;
    int          v;
    logic        mon;
    logic [13:0] mx;
    logic [13:0] my;
    logic        vid;
    logic [9:0]  px;
  } probe_t;

  exp_t   sbq[$];
  exp_t   hold;
  bit     have_hold = 0;
  int     cur_h = -1;
  int     cur_v = -1;
  int     cyc = 0;
  int     errors = 0;
  int     checks = 0;

  localparam logic [63:0] RESET_VEC =
    {6'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 14'd0, 14'd0, 5'd0, 1'b0};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] outs();
    return {6'b0, pixel_x, pixel_y, hsync, vsync, video_on, map_on,
            map_x, map_y, camera_y, frame_start};
  endfunction

  function automatic logic [63:0] pack_exp(input exp_t e, input logic fs);
    return {6'b0, e.px, e.py, e.hs, e.vs, e.vid, e.mon, e.mx, e.my, e.cam, fs};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference raster model: advances once per pixel period and queues the
  // outputs the DUT must present after that tick.
  initial begin
    int         mdiv;
    int         mh;
    int         mv;
    logic [4:0] mcam;
    exp_t       e;
    mdiv = 0; mh = 0; mv = 0; mcam = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        mdiv = 0; mh = 0; mv = 0; mcam = '0;
        have_hold = 0;
      end else if (mdiv == CD - 1) begin
        mdiv  = 0;
        e.h   = mh;
        e.v   = mv;
        e.hs  = !((mh >= HD + HF) && (mh < HD + HF + HS));
        e.vs  = !((mv >= VD + VF) && (mv < VD + VF + VS));
        e.vid = (mh < HD) && (mv < VD);
        e.px  = e.vid ? 10'(mh) : 10'd0;
        e.py  = e.vid ? 10'(mv) : 10'd0;
        e.mon = (mh >= MX0) && (mh < MX0 + MW) && (mv >= MY0) && (mv < MY0 + MH);
        e.mx  = e.mon ? 14'(mh - MX0) : 14'd0;
        e.my  = e.mon ? 14'(mv - MY0) : 14'd0;
        e.fs  = (mh == 0) && (mv == 0);
        if (mh == 0 && mv == VD) mcam = camera_y_in;
        e.cam = mcam;
        sbq.push_back(e);
        mh++;
        if (mh == HT) begin
          mh = 0;
          mv++;
          if (mv == VT) mv = 0;
        end
      end else begin
        mdiv++;
      end
    end
  end

  // Scoreboard consumer: compares on each DUT tick, checks hold between ticks.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (pixel_tick) begin
        check("tick_expected", 64'(sbq.size() > 0), 64'd1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          check($sformatf("pixel_%0d_%0d", e.h, e.v), outs(), pack_exp(e, e.fs));
          cur_h = e.h;
          cur_v = e.v;
          hold = e;
          have_hold = 1;
        end
      end else begin
        if (sbq.size() != 0) begin
          check("tick_missing", 64'(sbq.size()), 64'd0);
          sbq.delete();
        end
        if (have_hold) check("hold_between_ticks", outs(), pack_exp(hold, 1'b0));
      end
    end
  end

  task automatic wait_pix(input int h, input int v, output bit ok);
    int n;
    n = 0;
    ok = 0;
    while (!ok && n < 20000) begin
      @(negedge clk); #1;
      n++;
      if (pixel_tick && cur_h == h && cur_v == v) ok = 1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_pixel_%0d_%0d: got timeout expected pixel reached", h, v);
    end
  endtask

  task automatic wait_level(input int sel, input logic lvl, output int n);
    logic s;
    n = 0;
    s = (sel == 0) ? hsync : (sel == 1) ? vsync : frame_start;
    while (s !== lvl && n < 20000) begin
      @(negedge clk); #1;
      n++;
      s = (sel == 0) ? hsync : (sel == 1) ? vsync : frame_start;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    probe_t tbl[8];
    bit     ok;
    int     n;
    int     n2;
    int     t0;

    tbl[0] = '{h: 7,  v: 3,  mon: 1'b0, mx: 14'd0,  my: 14'd0,  vid: 1'b1, px: 10'd7};
    tbl[1] = '{h: 8,  v: 3,  mon: 1'b1, mx: 14'd0,  my: 14'd0,  vid: 1'b1, px: 10'd8};
    tbl[2] = '{h: 54, v: 3,  mon: 1'b1, mx: 14'd46, my: 14'd0,  vid: 1'b1, px: 10'd54};
    tbl[3] = '{h: 55, v: 3,  mon: 1'b0, mx: 14'd0,  my: 14'd0,  vid: 1'b1, px: 10'd55};
    tbl[4] = '{h: 63, v: 3,  mon: 1'b0, mx: 14'd0,  my: 14'd0,  vid: 1'b1, px: 10'd63};
    tbl[5] = '{h: 64, v: 3,  mon: 1'b0, mx: 14'd0,  my: 14'd0,  vid: 1'b0, px: 10'd0};
    tbl[6] = '{h: 54, v: 42, mon: 1'b1, mx: 14'd46, my: 14'd39, vid: 1'b1, px: 10'd54};
    tbl[7] = '{h: 8,  v: 43, mon: 1'b0, mx: 14'd0,  my: 14'd0,  vid: 1'b1, px: 10'd8};

    rst = 1'b1;
    camera_y_in = 5'd3;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", outs(), RESET_VEC);
    check("reset_pixel_tick", 64'(pixel_tick), 64'd0);
    rst = 1'b0;

    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!pixel_tick && n < 20);
    check("first_tick_clks", 64'(n), 64'(CD));
    check("first_frame_start", 64'(frame_start), 64'd1);

    // Line timing: hsync width and line period.
    wait_level(0, 1'b0, n);
    check("hsync_start_h", 64'(cur_h), 64'(HD + HF));
    wait_level(0, 1'b1, n);
    check("hsync_low_clks", 64'(n), 64'(HS * CD));
    wait_level(0, 1'b0, n2);
    check("line_period_clks", 64'(n + n2), 64'(HT * CD));

    for (int i = 0; i < 8; i++) begin
      wait_pix(tbl[i].h, tbl[i].v, ok);
      if (ok) begin
        check($sformatf("probe%0d_map_on", i), 64'(map_on), 64'(tbl[i].mon));
        check($sformatf("probe%0d_map_x", i), 64'(map_x), 64'(tbl[i].mx));
        check($sformatf("probe%0d_map_y", i), 64'(map_y), 64'(tbl[i].my));
        check($sformatf("probe%0d_video_on", i), 64'(video_on), 64'(tbl[i].vid));
        check($sformatf("probe%0d_pixel_x", i), 64'(pixel_x), 64'(tbl[i].px));
      end
    end

    wait_pix(0, VD, ok);
    check("camera_frame0", 64'(camera_y), 64'd3);

    wait_level(1, 1'b0, n);
    check("vsync_start_line", 64'(cur_v), 64'(VD + VF));
    wait_level(1, 1'b1, n);
    check("vsync_low_clks", 64'(n), 64'(VS * HT * CD));

    // Frame cadence, with a mid-frame camera change that must not show early.
    wait_level(2, 1'b1, n);
    t0 = cyc;
    @(negedge clk); #1;
    check("frame_start_width", 64'(frame_start), 64'd0);
    wait_pix(0, 20, ok);
    camera_y_in = 5'd17;
    wait_pix(HT - 1, VD - 1, ok);
    check("camera_held_before_sample", 64'(camera_y), 64'd3);
    wait_pix(0, VD, ok);
    check("camera_after_sample", 64'(camera_y), 64'd17);
    wait_level(2, 1'b1, n);
    check("frame_period_clks", 64'(cyc - t0), 64'(HT * VT * CD));

    wait_pix(0, 10, ok);
    camera_y_in = 5'd31;
    wait_pix(0, VD, ok);
    check("camera_31", 64'(camera_y), 64'd31);

    // Mid-frame reset.
    wait_pix(40, 30, ok);
    rst = 1'b1;
    @(negedge clk); #1;
    check("midreset_outputs", outs(), RESET_VEC);
    check("midreset_pixel_tick", 64'(pixel_tick), 64'd0);
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!frame_start && n < 20);
    check("midreset_frame_start_clks", 64'(n), 64'(CD));
    check("midreset_tick_with_frame_start", 64'(pixel_tick), 64'd1);

    wait_pix(10, 1, ok);
    check("run_on_after_reset", 64'(pixel_y), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/map_scan_gen.md
Name: map_scan_gen

Overview:
- Scan-side producer for the map renderer: generates 640x480@60 VGA timing and the map-window coordinates (map_x, map_y, map_on) consumed by the map/digit rendering path.
- Samples the level number (camera_y) once per frame, in vertical blanking, so the rendered digits never tear mid-frame.
- Sits between the system clock and the rgb renderer. All outputs are registered and pixel-aligned.

Parameters:
- CLK_DIV, 4, system clocks per pixel; 100 MHz in gives 25 MHz pixel rate.
- H_DISPLAY, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch.
- H_SYNC, 96, hsync width.
- H_BACK, 48, horizontal back porch.
- V_DISPLAY, 480, visible lines.
- V_FRONT, 10, vertical front porch.
- V_SYNC, 2, vsync width.
- V_BACK, 33, vertical back porch.
- MAP_X0, 85, map window left edge in screen pixels.
- MAP_Y0, 10, map window top edge in screen pixels.
- MAP_W, 470, map window width.
- MAP_H, 460, map window height.
- PHY_WIDTH, 14, width of map_x/map_y.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- camera_y_in  in  5  live level index from game logic.
- pixel_tick  out  1  one-clk pulse per pixel period.
- hsync  out  1  active-low horizontal sync.
- vsync  out  1  active-low vertical sync.
- video_on  out  1  high inside the 640x480 visible area.
- pixel_x  out  10  current screen column.
- pixel_y  out  10  current screen row.
- map_on  out  1  high inside the map window.
- map_x  out  PHY_WIDTH  pixel_x-MAP_X0 when map_on, else 0.
- map_y  out  PHY_WIDTH  pixel_y-MAP_Y0 when map_on, else 0.
- camera_y  out  5  frame-stable level index.
- frame_start  out  1  one-clk pulse marking pixel (0,0).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: div=0, h=0, v=0, pixel_tick=0, hsync=1, vsync=1, video_on=0, pixel_x=0, pixel_y=0, map_on=0, map_x=0, map_y=0, camera_y=0, frame_start=0.
- Reset mid-frame: same reset values, applied on the next clk edge. After release, counting restarts from h=0, v=0.
- Divider: div counts 0..CLK_DIV-1 and wraps. pixel_tick is registered high for the single clk in which div==CLK_DIV-1.
- Horizontal counter: H_TOTAL=800. On each tick, h increments and wraps 799->0.
- Vertical counter: V_TOTAL=525. v increments only when h wraps, and wraps 524->0.
- Output update: on each tick, every output register loads the decode of the pre-increment (h,v). Outputs therefore lag the counters by one pixel period and are mutually aligned. Between ticks, outputs hold.
- hsync = 0 iff 656 <= h <= 751.
- vsync = 0 iff 490 <= v <= 491.
- video_on = (h<640) && (v<480).
- pixel_x = h and pixel_y = v when video_on; otherwise both 0.
- map_on = MAP_X0<=h<MAP_X0+MAP_W && MAP_Y0<=v<MAP_Y0+MAP_H. Use unsigned compares at 11-bit width; no overflow is possible.
- map_x/map_y carry the subtraction zero-extended to PHY_WIDTH when map_on, else 0.
- camera_y sampling: sampled from camera_y_in on the tick where (h,v)==(0,V_DISPLAY). It holds until the next such tick. A change of camera_y_in at any other time has no visible effect until then.
- frame_start: loaded on the tick as (h==0 && v==0). Because the register clears on the next clk, it is a one-clk-wide pulse with period 800*525*CLK_DIV clks.
- CLK_DIV=1: pixel_tick is constant 1 after the first clk out of reset. All behaviour above still holds.

Decomposition:
- Shared package map_pkg holds:
  - VGA timing constants (H_*, V_*, H_TOTAL, V_TOTAL);
  - map window constants (MAP_X0/Y0/W/H);
  - MAP_COLOR and DIGIT_COLOR;
  - DIGIT_WIDTH and the digit origin constants, so the renderer and this block share one definition.
- One sub-module, vga_sync_counter: divider plus h/v counters with wrap. It outputs tick, h, v.
- This block does the decode and output registering.

Test Plan:
- Reset: assert rst for 3 clks -> all outputs at reset values. First pixel_tick on clk 4 after release (CLK_DIV=4).
- Line timing: count ticks after reset -> hsync low from the output of tick 656 through tick 751 (96 ticks). video_on drops after tick 640. Line period 3200 clks.
- Map corners:
  - pixel (85,10) -> map_on=1, map_x=0, map_y=0;
  - (554,469) -> map_x=469, map_y=459;
  - (555,10) and (84,10) -> map_on=0, map_x=0;
  - (85,470) -> map_on=0.
- camera_y stability: camera_y_in=3 through frame 0. Change to 17 at v=200 -> camera_y stays 3 until the tick at (0,480), then 17. Also check 31 -> 31.
- Frame cadence: frame_start pulses exactly 1 clk wide, 1,680,000 clks apart. vsync is low for 2 lines (6400 clks) starting at line 490.
- Mid-frame reset: pulse rst at v=300, h=400 -> next clk shows reset values. frame_start is seen exactly 1 clk after the first tick following release.
